// File: rtl/mips_pc_unit_if.sv
// mips_pc_unit_if: bundles the PC stage's control inputs and status outputs.
//   slave  modport : used by mips_pc_unit (takes control, drives PC/status)
//   master modport : used by the controller/testbench side
// Control : pc_update, stall, is_branch, branch_imm[15:0], jump,
//           jump_index[25:0], jr, jr_target[31:0]
// Status  : pc[31:0], pc_plus4[31:0], pc_valid, flush, addr_err,
//           redirect_cnt[15:0]
interface mips_pc_unit_if;
  logic        pc_update;
  logic        stall;
  logic        is_branch;
  logic [15:0] branch_imm;
  logic        jump;
  logic [25:0] jump_index;
  logic        jr;
  logic [31:0] jr_target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        pc_valid;
  logic        flush;
  logic        addr_err;
  logic [15:0] redirect_cnt;

  modport slave (
    input  pc_update, stall, is_branch, branch_imm, jump, jump_index, jr,
           jr_target,
    output pc, pc_plus4, pc_valid, flush, addr_err, redirect_cnt
  );

  modport master (
    output pc_update, stall, is_branch, branch_imm, jump, jump_index, jr,
           jr_target,
    input  pc, pc_plus4, pc_valid, flush, addr_err, redirect_cnt
  );
endinterface

// File: rtl/mips_pc_unit.sv
// mips_pc_unit: architectural PC register with next-PC selection
// (jr > jump > branch > sequential), redirect flush pulse and a sticky
// misaligned-JR halt trap.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - mips_pc_unit_if.slave (control in, PC/status out)
// Parameter:
//   RESET_PC - word-aligned PC loaded on reset
// Optional feature macro:
//   MIPS_PC_REDIRECT_CNT_EN - when defined, redirect_cnt counts flushing
//   advances (saturating at 16'hFFFF); otherwise redirect_cnt is tied to 0.
module mips_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           rst,
  mips_pc_unit_if.slave  bus
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t      state;
  logic [31:0] pc_q;
  logic        pc_valid_q;
  logic        flush_q;
  logic        addr_err_q;
  logic [31:0] pc_plus4;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic        adv;
  logic        jr_misaligned;
  logic        redirect;

  assign pc_plus4      = pc_q + 32'd4;
  assign br_target     = pc_plus4 + {{14{bus.branch_imm[15]}}, bus.branch_imm, 2'b00};
  assign j_target      = {pc_plus4[31:28], bus.jump_index, 2'b00};
  assign adv           = (state == RUN) && bus.pc_update && !bus.stall;
  assign jr_misaligned = bus.jr && (bus.jr_target[1:0] != 2'b00);
  // Any taken non-sequential source flushes, even when the target equals pc+4.
  assign redirect      = adv && !jr_misaligned && (bus.jr || bus.jump || bus.is_branch);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= BOOT;
      pc_q       <= RESET_PC;
      pc_valid_q <= 1'b0;
      flush_q    <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      flush_q <= redirect;
      case (state)
        BOOT: begin
          state      <= RUN;
          pc_valid_q <= 1'b1;
        end
        RUN: begin
          if (adv) begin
            if (jr_misaligned) begin
              // Trap: PC holds so software can inspect the faulting instruction.
              state      <= HALT;
              pc_valid_q <= 1'b0;
              addr_err_q <= 1'b1;
            end else if (bus.jr) begin
              pc_q <= bus.jr_target;
            end else if (bus.jump) begin
              pc_q <= j_target;
            end else if (bus.is_branch) begin
              pc_q <= br_target;
            end else begin
              pc_q <= pc_plus4;
            end
          end
        end
        default: begin
          // HALT: only reset leaves.
          state      <= HALT;
          pc_valid_q <= 1'b0;
          addr_err_q <= 1'b1;
        end
      endcase
    end
  end

`ifdef MIPS_PC_REDIRECT_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= 16'h0000;
    else if (redirect && (cnt_q != 16'hFFFF))
      cnt_q <= cnt_q + 16'd1;
  end

  assign bus.redirect_cnt = cnt_q;
`else
  assign bus.redirect_cnt = 16'h0000;
`endif

  assign bus.pc       = pc_q;
  assign bus.pc_plus4 = pc_plus4;
  assign bus.pc_valid = pc_valid_q;
  assign bus.flush    = flush_q;
  assign bus.addr_err = addr_err_q;

endmodule

// File: tb/tb_mips_pc_unit.sv
module tb_mips_pc_unit;
  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mips_pc_unit_if bus();

  mips_pc_unit #(.RESET_PC(RST_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
    logic        flush;
    logic        err;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Reference model: mode 0=booting, 1=running, 2=halted.
  int          m_mode;
  logic [31:0] m_pc;
  logic        m_flush;
  logic        m_err;
  int          m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // One clock: drive inputs, advance the model, queue the expected outputs.
  task automatic step(input logic r, input logic upd, input logic stl,
                      input logic br, input logic [15:0] imm,
                      input logic j, input logic [25:0] idx,
                      input logic jrr, input logic [31:0] tgt);
    exp_t e;
    longint seq;
    @(negedge clk);
    rst = r; bus.pc_update = upd; bus.stall = stl; bus.is_branch = br;
    bus.branch_imm = imm; bus.jump = j; bus.jump_index = idx;
    bus.jr = jrr; bus.jr_target = tgt;
    if (r) begin
      m_mode = 0; m_pc = RST_PC; m_flush = 0; m_err = 0; m_cnt = 0;
    end else begin
      m_flush = 0;
      if (m_mode == 0) m_mode = 1;
      else if (m_mode == 1 && upd && !stl) begin
        seq = (longint'(m_pc) + 4) % 64'h1_0000_0000;
        if (jrr) begin
          if (tgt % 4 != 0) begin m_mode = 2; m_err = 1; end
          else begin m_pc = tgt; m_flush = 1; end
        end else if (j) begin
          m_pc = 32'((seq / 64'h1000_0000) * 64'h1000_0000 + longint'(idx) * 4);
          m_flush = 1;
        end else if (br) begin
          m_pc = 32'(seq + longint'($signed(imm)) * 4);
          m_flush = 1;
        end else m_pc = 32'(seq);
        if (m_flush && m_cnt < 65535) m_cnt++;
      end
    end
    e.pc = m_pc; e.pc_plus4 = m_pc + 32'd4; e.valid = (m_mode == 1);
    e.flush = m_flush; e.err = m_err;
`ifdef MIPS_PC_REDIRECT_CNT_EN
    e.cnt = 16'(m_cnt);
`else
    e.cnt = 16'h0000;
`endif
    @(posedge clk);
    exp_q.push_back(e);
  endtask

  // Monitor: every cycle the DUT presents a new registered state; compare it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc",           bus.pc,                    e.pc);
        chk("pc_plus4",     bus.pc_plus4,              e.pc_plus4);
        chk("pc_valid",     {31'b0, bus.pc_valid},     {31'b0, e.valid});
        chk("flush",        {31'b0, bus.flush},        {31'b0, e.flush});
        chk("addr_err",     {31'b0, bus.addr_err},     {31'b0, e.err});
        chk("redirect_cnt", {16'b0, bus.redirect_cnt}, {16'b0, e.cnt});
      end
    end
  end

  initial begin
    logic [31:0] t;
    int w;
    rst = 1; bus.pc_update = 0; bus.stall = 0; bus.is_branch = 0;
    bus.branch_imm = 0; bus.jump = 0; bus.jump_index = 0; bus.jr = 0;
    bus.jr_target = 0;
    m_mode = 0; m_pc = RST_PC; m_flush = 0; m_err = 0; m_cnt = 0;

    // Reset/boot, then sequential advances and a stall.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);              // boot -> run, update ignored
    repeat (3) step(0, 1, 0, 0, 0, 0, 0, 0, 0);   // 0x0040_000C
    step(0, 1, 1, 1, 16'h0004, 1, 26'h1, 0, 0);   // stall wins
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);              // 0x0040_0010
    step(0, 1, 0, 1, 16'hFFFC, 0, 0, 0, 0);       // branch back to 0x0040_0004
    step(0, 1, 0, 1, 16'h0000, 0, 0, 0, 0);       // branch to pc+4 still flushes
    // Priority jr > jump > branch, then J-type.
    step(0, 1, 0, 1, 16'h0100, 1, 26'h3, 1, 32'h0000_1000);
    step(0, 1, 0, 1, 16'h0100, 1, 26'h000_0010, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Misaligned JR traps; updates ignored; reset clears.
    step(0, 1, 0, 0, 0, 0, 0, 1, 32'h0000_1002);
    repeat (2) step(0, 1, 0, 1, 16'h0010, 1, 26'h5, 1, 32'h0000_2000);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Wrap.
    step(0, 1, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 16'h8000, 0, 0, 0, 0);       // negative offset wraps

    // Randomized phase.
    for (int i = 0; i < 1500; i++) begin
      t = $urandom;
      if ($urandom_range(0, 9) != 0) t[1:0] = 2'b00;
      step(($urandom_range(0, 60) == 0) || (m_mode == 2 && $urandom_range(0, 3) == 0),
           $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
           1'($urandom), 16'($urandom), $urandom_range(0, 3) == 0, 26'($urandom),
           $urandom_range(0, 5) == 0, t);
    end

    w = 0;
    while (exp_q.size() > 0 && w < 10) begin @(posedge clk); w++; end
    @(posedge clk);
    n_chk++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
